// File: rtl/qformat_convert_pipe_if.sv
// Handshake bundle for qformat_convert_pipe: input sample stream with per-sample mode,
// output sample stream with overflow flag, and the overflow event counter.
interface qformat_convert_pipe_if #(
    parameter int MI = 7,
    parameter int FI = 8,
    parameter int MO = 15,
    parameter int FO = 16,
    parameter int CW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [MI+FI:0]    in_data;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [MO+FO:0]    out_data;
    logic              out_ovf;
    logic [CW-1:0]     ovf_count;
    logic              ovf_clear;

    modport slave (
        input  in_valid, in_data, mode, out_ready, ovf_clear,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport master (
        output in_valid, in_data, mode, out_ready, ovf_clear,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface

// File: rtl/qformat_convert_pipe.sv
// Two-stage signed fixed-point converter Q(MI.FI) -> Q(MO.FO): stage 1 aligns the binary
// point (truncate or round half up), stage 2 fits the integer part (saturate or wrap).
module qformat_convert_pipe #(
    parameter int MI = 7,
    parameter int FI = 8,
    parameter int MO = 15,
    parameter int FO = 16,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qformat_convert_pipe_if.slave bus
);
    localparam int IW = 1 + MI + FI;
    localparam int OW = 1 + MO + FO;
    localparam int MX = (MI > MO) ? MI : MO;
    localparam int FX = (FI > FO) ? FI : FO;
    localparam int W  = 3 + MX + FX;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [OW-1:0] SAT_POS = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SAT_NEG = {1'b1, {(OW-1){1'b0}}};

    logic                advance;
    logic signed [W-1:0] in_ext;
    logic signed [W-1:0] aligned;

    logic                s1_valid_q, s1_valid_d;
    logic signed [W-1:0] s1_data_q,  s1_data_d;
    logic                s1_sat_q,   s1_sat_d;
    logic                out_valid_q, out_valid_d;
    logic [OW-1:0]       out_data_q,  out_data_d;
    logic                out_ovf_q,   out_ovf_d;
    logic [CW-1:0]       ovf_count_q, ovf_count_d;

    logic [W-OW:0]       top_bits;
    logic                fit_ovf;
    logic [OW-1:0]       fit_data;

    // One stall signal for the whole pipe keeps both stages in lockstep.
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    assign in_ext = {{(W-IW){bus.in_data[IW-1]}}, bus.in_data};

    generate
        if (FO >= FI) begin : g_widen
            always_comb aligned = in_ext <<< (FO - FI);
        end else begin : g_narrow
            localparam logic signed [W-1:0] HALF = W'(1) << (FI - FO - 1);
            logic signed [W-1:0] biased;
            // Bias by half an output LSB before the floor shift; the carry may reach the integer part.
            always_comb begin
                biased  = in_ext + (bus.mode[0] ? HALF : '0);
                aligned = biased >>> (FI - FO);
            end
        end
    endgenerate

    // Value fits only when every bit from the output MSB upward matches the sign.
    always_comb begin
        top_bits = s1_data_q[W-1:OW-1];
        fit_ovf  = !((&top_bits) || !(|top_bits));
        fit_data = s1_data_q[OW-1:0];
        if (fit_ovf && s1_sat_q) begin
            fit_data = s1_data_q[W-1] ? SAT_NEG : SAT_POS;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        ovf_count_d = ovf_count_q;

        if (advance) begin
            s1_valid_d  = bus.in_valid;
            s1_data_d   = aligned;
            s1_sat_d    = bus.mode[1];
            out_valid_d = s1_valid_q;
            out_data_d  = fit_data;
            out_ovf_d   = fit_ovf && s1_valid_q;
        end

        if (bus.ovf_clear) begin
            ovf_count_d = '0;
        end else if (out_valid_q && bus.out_ready && out_ovf_q && (ovf_count_q != CNT_MAX)) begin
            ovf_count_d = ovf_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.ovf_count = ovf_count_q;
endmodule

// File: tb/tb_qformat_convert_pipe.sv
// Scoreboard bench for qformat_convert_pipe across three parameter sets (widening default,
// narrowing Q3.4->Q1.2 with a 2-bit counter, and Q3.4->Q3.0 rounding carry).
module tb_qformat_convert_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {logic [7:0] din; logic [1:0] mode; logic [3:0] dout; logic ovf;} vec_s_t;
    typedef struct packed {logic [3:0] dout; logic ovf;} res_s_t;

    vec_s_t      stim_s[$];
    res_s_t      exp_s[$];
    res_s_t      obs_s[$];
    logic [31:0] exp_a[$];

    always #5 clk = ~clk;

    qformat_convert_pipe_if #(.MI(7), .FI(8), .MO(15), .FO(16), .CW(8)) ia ();
    qformat_convert_pipe_if #(.MI(3), .FI(4), .MO(1),  .FO(2),  .CW(2)) ib ();
    qformat_convert_pipe_if #(.MI(3), .FI(4), .MO(3),  .FO(0),  .CW(8)) ic ();

    qformat_convert_pipe #(.MI(7), .FI(8), .MO(15), .FO(16), .CW(8)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    qformat_convert_pipe #(.MI(3), .FI(4), .MO(1),  .FO(2),  .CW(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));
    qformat_convert_pipe #(.MI(3), .FI(4), .MO(3),  .FO(0),  .CW(8)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ic));

    // Integer reference for Q3.4 -> Q1.2: floor division by 4, optional +half LSB, range [-8,7].
    function automatic res_s_t model_b(input logic [7:0] din, input logic [1:0] mode);
        int v;
        int q;
        res_s_t r;
        v = int'($signed(din));
        if (mode[0]) v = v + 2;
        q = (v >= 0) ? (v / 4) : -((3 - v) / 4);
        r.ovf = (q > 7) || (q < -8);
        if (r.ovf && mode[1]) q = (q > 0) ? 7 : -8;
        r.dout = q[3:0];
        return r;
    endfunction

    task automatic idle_all();
        ia.in_valid = 1'b0; ia.in_data = '0; ia.mode = 2'b00; ia.out_ready = 1'b1; ia.ovf_clear = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.mode = 2'b00; ib.out_ready = 1'b1; ib.ovf_clear = 1'b0;
        ic.in_valid = 1'b0; ic.in_data = '0; ic.mode = 2'b00; ic.out_ready = 1'b1; ic.ovf_clear = 1'b0;
    endtask

    // Streams stim_s into dut_b or dut_c; expected results are queued on accept, observed on delivery.
    task automatic drive_small(input bit on_c, input int stall_pct);
        int sent;
        int got;
        int n;
        logic acc;
        logic dlv;
        logic ordy;
        logic [3:0] od;
        logic od_ovf;
        vec_s_t cur;
        sent = 0;
        got = 0;
        n = stim_s.size();
        for (int cyc = 0; cyc < 20 * n + 20 && got < n; cyc++) begin
            cur = (sent < n) ? stim_s[sent] : '0;
            ordy = ($urandom_range(0, 99) >= stall_pct);
            if (on_c) begin
                ic.in_valid = (sent < n); ic.in_data = cur.din; ic.mode = cur.mode; ic.out_ready = ordy;
            end else begin
                ib.in_valid = (sent < n); ib.in_data = cur.din; ib.mode = cur.mode; ib.out_ready = ordy;
            end
            #1;
            acc    = on_c ? (ic.in_valid && ic.in_ready) : (ib.in_valid && ib.in_ready);
            dlv    = on_c ? (ic.out_valid && ic.out_ready) : (ib.out_valid && ib.out_ready);
            od     = on_c ? ic.out_data : ib.out_data;
            od_ovf = on_c ? ic.out_ovf : ib.out_ovf;
            if (acc) begin
                exp_s.push_back({cur.dout, cur.ovf});
                sent++;
            end
            if (dlv) begin
                obs_s.push_back({od, od_ovf});
                got++;
                $display("tx %s #%0d: out_data=%h out_ovf=%b", on_c ? "c" : "b", got, od, od_ovf);
            end
            @(posedge clk); #1;
        end
        idle_all();
        stim_s.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a: got %b, required 0", ia.out_valid); end
        n_checks++; if (ia.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data_a: got %h, required 0", ia.out_data); end
        n_checks++; if (ia.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf_a: got %b, required 0", ia.out_ovf); end
        n_checks++; if (ia.ovf_count !== 8'h0) begin n_fail++; $display("FAIL reset_ovf_count_a: got %h, required 0", ia.ovf_count); end
        n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_b: got %b, required 0", ib.out_valid); end
        n_checks++; if (ib.ovf_count !== 2'd0) begin n_fail++; $display("FAIL reset_ovf_count_b: got %h, required 0", ib.ovf_count); end
        n_checks++; if (ic.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_c: got %b, required 0", ic.out_valid); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a: got %b, required 1", ia.in_ready); end
        n_checks++; if (ib.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b: got %b, required 1", ib.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_widen();
        logic [15:0] vin [3] = '{16'h7FFF, 16'h0001, 16'hFF01};
        logic [31:0] vex [3] = '{32'h007F_FF00, 32'h0000_0100, 32'hFFFF_0100};
        logic [31:0] e;
        int sent;
        int got;
        // Single sample: accept edge, one empty cycle, valid on the second edge.
        ia.in_valid = 1'b1; ia.in_data = 16'h8000; ia.mode = 2'b00;
        #1;
        n_checks++; if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL widen_accept: in_ready %b, required 1", ia.in_ready); end
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL widen_latency_early: out_valid %b after 1 cycle, required 0", ia.out_valid); end
        @(posedge clk); #1;
        n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL widen_latency: out_valid %b after 2 cycles, required 1", ia.out_valid); end
        n_checks++; if (ia.out_data !== 32'hFF80_0000) begin n_fail++; $display("FAIL widen_min: got %h, required ff800000", ia.out_data); end
        n_checks++; if (ia.out_ovf !== 1'b0) begin n_fail++; $display("FAIL widen_min_ovf: got %b, required 0", ia.out_ovf); end
        $display("tx a: out_data=%h out_ovf=%b", ia.out_data, ia.out_ovf);
        @(posedge clk); #1;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            ia.in_valid = (sent < 3);
            ia.in_data = (sent < 3) ? vin[sent] : 16'h0;
            ia.mode = 2'(cyc);
            #1;
            if (ia.in_valid && ia.in_ready) begin
                exp_a.push_back(vex[sent]);
                sent++;
            end
            if (ia.out_valid && ia.out_ready) begin
                got++;
                $display("tx a: out_data=%h out_ovf=%b", ia.out_data, ia.out_ovf);
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++; $display("FAIL widen_extra: unexpected output %h, required none", ia.out_data);
                end else begin
                    e = exp_a.pop_front();
                    if (ia.out_data !== e || ia.out_ovf !== 1'b0) begin n_fail++; $display("FAIL widen_data: got %h ovf %b, required %h ovf 0", ia.out_data, ia.out_ovf, e); end
                end
            end
            @(posedge clk); #1;
        end
        idle_all();
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL widen_count: got %0d outputs, required 3", got); end
        exp_a.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] vin [5] = '{16'h0100, 16'hFE00, 16'h1234, 16'h8001, 16'h7F7F};
        logic [31:0] e;
        logic [31:0] prev_data;
        logic prev_stall;
        logic saw_block;
        int sent;
        int got;
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            ia.in_valid = (sent < 5);
            ia.in_data = (sent < 5) ? vin[sent] : 16'h0;
            ia.out_ready = !(cyc >= 2 && cyc <= 5);
            #1;
            n_checks++;
            if (ia.in_ready !== (!ia.out_valid || ia.out_ready)) begin n_fail++; $display("FAIL bp_in_ready: got %b, required %b", ia.in_ready, !ia.out_valid || ia.out_ready); end
            if (ia.in_ready === 1'b0) saw_block = 1'b1;
            if (prev_stall) begin
                n_checks++;
                if (ia.out_valid !== 1'b1 || ia.out_data !== prev_data) begin n_fail++; $display("FAIL bp_hold: got valid %b data %h, required valid 1 data %h", ia.out_valid, ia.out_data, prev_data); end
            end
            if (ia.in_valid && ia.in_ready) begin
                exp_a.push_back(32'(int'($signed(vin[sent])) * 256));
                sent++;
            end
            if (ia.out_valid && ia.out_ready) begin
                got++;
                $display("tx a: out_data=%h out_ovf=%b", ia.out_data, ia.out_ovf);
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: unexpected output %h, required none", ia.out_data);
                end else begin
                    e = exp_a.pop_front();
                    if (ia.out_data !== e) begin n_fail++; $display("FAIL bp_data: got %h, required %h", ia.out_data, e); end
                end
            end
            prev_stall = ia.out_valid && !ia.out_ready;
            prev_data = ia.out_data;
            @(posedge clk); #1;
        end
        idle_all();
        n_checks++; if (got != 5 || exp_a.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d outputs (%0d pending), required 5 (0)", got, exp_a.size()); end
        n_checks++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_drop: in_ready low seen %b, required 1", saw_block); end
        exp_a.delete();
    endtask

    task automatic test_narrow_modes();
        res_s_t e;
        res_s_t o;
        int n_exp;
        stim_s.push_back({8'h38, 2'b10, 4'h7, 1'b1});
        stim_s.push_back({8'h38, 2'b00, 4'hE, 1'b1});
        stim_s.push_back({8'h06, 2'b01, 4'h2, 1'b0});
        stim_s.push_back({8'h06, 2'b00, 4'h1, 1'b0});
        stim_s.push_back({8'hFA, 2'b00, 4'hE, 1'b0});
        stim_s.push_back({8'hFA, 2'b01, 4'hF, 1'b0});
        stim_s.push_back({8'hC8, 2'b10, 4'h8, 1'b1});
        stim_s.push_back({8'hC8, 2'b00, 4'h2, 1'b1});
        n_exp = stim_s.size();
        drive_small(1'b0, 0);
        n_checks++; if (obs_s.size() != n_exp) begin n_fail++; $display("FAIL narrow_count: got %0d outputs, required %0d", obs_s.size(), n_exp); end
        while (exp_s.size() > 0 && obs_s.size() > 0) begin
            e = exp_s.pop_front();
            o = obs_s.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL narrow_data: got data=%h ovf=%b, required data=%h ovf=%b", o.dout, o.ovf, e.dout, e.ovf); end
        end
        exp_s.delete(); obs_s.delete();
    endtask

    task automatic test_round_carry();
        res_s_t e;
        res_s_t o;
        int n_exp;
        stim_s.push_back({8'h7F, 2'b11, 4'h7, 1'b1});
        stim_s.push_back({8'h7F, 2'b01, 4'h8, 1'b1});
        stim_s.push_back({8'h7F, 2'b00, 4'h7, 1'b0});
        stim_s.push_back({8'h80, 2'b00, 4'h8, 1'b0});
        stim_s.push_back({8'h81, 2'b01, 4'h8, 1'b0});
        n_exp = stim_s.size();
        drive_small(1'b1, 25);
        n_checks++; if (obs_s.size() != n_exp) begin n_fail++; $display("FAIL carry_count: got %0d outputs, required %0d", obs_s.size(), n_exp); end
        while (exp_s.size() > 0 && obs_s.size() > 0) begin
            e = exp_s.pop_front();
            o = obs_s.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL carry_data: got data=%h ovf=%b, required data=%h ovf=%b", o.dout, o.ovf, e.dout, e.ovf); end
        end
        exp_s.delete(); obs_s.delete();
    endtask

    task automatic test_back_to_back();
        res_s_t e;
        res_s_t o;
        res_s_t r;
        logic [7:0] d;
        logic [1:0] m;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            r = model_b(d, m);
            stim_s.push_back({d, m, r.dout, r.ovf});
        end
        drive_small(1'b0, 30);
        n_checks++; if (obs_s.size() != 30) begin n_fail++; $display("FAIL b2b_count: got %0d outputs, required 30", obs_s.size()); end
        while (exp_s.size() > 0 && obs_s.size() > 0) begin
            e = exp_s.pop_front();
            o = obs_s.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_data: got data=%h ovf=%b, required data=%h ovf=%b", o.dout, o.ovf, e.dout, e.ovf); end
        end
        exp_s.delete(); obs_s.delete();
    endtask

    task automatic test_counter();
        ib.ovf_clear = 1'b1;
        @(posedge clk); #1;
        ib.ovf_clear = 1'b0;
        n_checks++; if (ib.ovf_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d, required 0", ib.ovf_count); end
        stim_s.push_back({8'h06, 2'b00, 4'h1, 1'b0});
        drive_small(1'b0, 0);
        n_checks++; if (ib.ovf_count !== 2'd0) begin n_fail++; $display("FAIL cnt_no_ovf: got %0d, required 0", ib.ovf_count); end
        stim_s.push_back({8'h38, 2'b10, 4'h7, 1'b1});
        drive_small(1'b0, 0);
        n_checks++; if (ib.ovf_count !== 2'd1) begin n_fail++; $display("FAIL cnt_incr: got %0d, required 1", ib.ovf_count); end
        repeat (4) stim_s.push_back({8'h38, 2'b10, 4'h7, 1'b1});
        drive_small(1'b0, 0);
        n_checks++; if (ib.ovf_count !== 2'd3) begin n_fail++; $display("FAIL cnt_sticky: got %0d, required 3", ib.ovf_count); end
        n_checks++; if (obs_s.size() != 6) begin n_fail++; $display("FAIL cnt_outputs: got %0d outputs, required 6", obs_s.size()); end
        exp_s.delete(); obs_s.delete();
        // Clear lands on the same edge as an overflowed handshake.
        ib.in_valid = 1'b1; ib.in_data = 8'h38; ib.mode = 2'b10; ib.out_ready = 1'b0;
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        for (int i = 0; i < 10 && ib.out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (ib.out_valid !== 1'b1 || ib.out_ovf !== 1'b1) begin n_fail++; $display("FAIL cnt_pending: got valid %b ovf %b, required 1 1", ib.out_valid, ib.out_ovf); end
        ib.out_ready = 1'b1;
        ib.ovf_clear = 1'b1;
        @(posedge clk); #1;
        ib.ovf_clear = 1'b0;
        $display("tx b: clear with overflowed handshake, ovf_count=%0d", ib.ovf_count);
        n_checks++; if (ib.ovf_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear_priority: got %0d, required 0", ib.ovf_count); end
        idle_all();
    endtask

    task automatic test_reset_midstream();
        int stale;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.in_valid = 1'b1;
            ia.in_data = 16'h0400 + 16'(i);
            @(posedge clk); #1;
        end
        n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: out_valid %b, required 1", ia.out_valid); end
        ia.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: out_valid %b, required 0", ia.out_valid); end
        n_checks++; if (ia.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: out_data %h, required 0", ia.out_data); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ia.out_valid !== 1'b0) stale++;
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_mid_stale: %0d cycles with out_valid after reset, required 0", stale); end
        exp_a.delete();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_widen();
        test_backpressure();
        test_narrow_modes();
        test_round_carry();
        test_back_to_back();
        test_counter();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
